// File: rtl/qspi_ctrl_pkg.sv
// qspi_ctrl_pkg: command constants, phase lengths and FSM state type for the QSPI XIP read controller
package qspi_ctrl_pkg;
  localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
  localparam int CMD_BITS = 8;
  localparam int ADDR_NIB = 6;
  localparam int MODE_NIB = 2;
  localparam int DUMMY_CYC = 4;
  localparam int DATA_NIB = 8;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, GAP} qspi_state_e;
  function automatic logic [4:0] phase_len(input qspi_state_e s);
    return s == CMD ? 5'(CMD_BITS) : s == ADDR ? 5'(ADDR_NIB) : s == MODE ? 5'(MODE_NIB) :
           s == DUMMY ? 5'(DUMMY_CYC) : 5'(DATA_NIB);
  endfunction
endpackage

// File: rtl/qspi_rr_arb.sv
// qspi_rr_arb: 2-way round-robin arbiter; on a tie the port not granted last wins
module qspi_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt_o = !en_i ? 2'b00 : &req_i ? (ptr_q ? 2'b10 : 2'b01) : req_i;
    ptr_d = |gnt_o ? gnt_o[0] : ptr_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/qspi_xip_ctrl.sv
// qspi_xip_ctrl: shares one QSPI flash between ifetch and data ports, one 0xEB quad read per grant
module qspi_xip_ctrl
  import qspi_ctrl_pkg::*;
#(
  parameter int         SCK_HALF  = 1,
  parameter int         CS_GAP    = 2,
  parameter logic [7:0] MODE_BYTE = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifetch_req_i,
  input  logic [23:0] ifetch_addr_i,
  output logic        ifetch_gnt_o,
  output logic        ifetch_rvalid_o,
  output logic [31:0] ifetch_rdata_o,
  input  logic        data_req_i,
  input  logic [23:0] data_addr_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic [3:0]  qspi_io_i,
  output logic [3:0]  qspi_io_o,
  output logic [3:0]  qspi_io_t,
  output logic        qspi_ck_o,
  output logic        qspi_cs_o
);
  localparam int HW = $clog2(SCK_HALF + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  qspi_state_e   state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          ck_q, ck_d, port_q, port_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    gnt;
  logic          busy, tick, last, rvalid;

  qspi_rr_arb u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (state_q == IDLE && rst_ni),
    .req_i ({data_req_i, ifetch_req_i}),
    .gnt_o (gnt)
  );

  assign busy   = state_q inside {CMD, ADDR, MODE, DUMMY, DATA};
  assign tick   = hcnt_q == HW'(SCK_HALF - 1);
  assign last   = cnt_q == phase_len(state_q) - 5'd1;
  assign rvalid = state_q == GAP && gcnt_q == '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      ck_q    <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
      ck_q    <= ck_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // SCK rises on the sampling edge; the final rise is replaced by the jump to GAP
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    cnt_d   = cnt_q;
    ck_d    = ck_q;
    port_d  = port_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      if (|gnt) begin
        state_d = CMD;
        hcnt_d  = '0;
        cnt_d   = '0;
        ck_d    = 1'b0;
        port_d  = gnt[1];
        addr_d  = (gnt[1] ? data_addr_i : ifetch_addr_i) & 24'hFFFFFC;
      end
    end else if (state_q == GAP) begin
      gcnt_d  = gcnt_q + 1'b1;
      state_d = gcnt_q == GW'(CS_GAP - 1) ? IDLE : GAP;
    end else begin
      hcnt_d = tick ? '0 : hcnt_q + 1'b1;
      if (tick && !ck_q) begin
        if (state_q == DATA) rdata_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = qspi_io_i;
        if (state_q == DATA && last) begin
          state_d = GAP;
          gcnt_d  = '0;
        end else ck_d = 1'b1;
      end else if (tick) begin
        ck_d  = 1'b0;
        cnt_d = last ? 5'd0 : cnt_q + 5'd1;
        if (last) state_d = state_q == CMD ? ADDR : state_q == ADDR ? MODE : state_q == MODE ? DUMMY : DATA;
      end
    end
  end

  always_comb begin
    qspi_cs_o       = ~busy;
    qspi_ck_o       = ck_q;
    qspi_io_t       = state_q == CMD ? 4'b1110 : state_q inside {ADDR, MODE} ? 4'h0 : 4'hF;
    qspi_io_o       = state_q == CMD  ? {3'b000, CMD_QUAD_READ[3'd7 - cnt_q[2:0]]} :
                      state_q == ADDR ? addr_q[5'd20 - {cnt_q[2:0], 2'b00} +: 4] :
                      state_q == MODE ? (cnt_q[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4]) : 4'h0;
    ifetch_gnt_o    = gnt[0];
    data_gnt_o      = gnt[1];
    ifetch_rvalid_o = rvalid & ~port_q;
    data_rvalid_o   = rvalid & port_q;
    ifetch_rdata_o  = rdata_q;
    data_rdata_o    = rdata_q;
  end
endmodule

// File: tb/tb_qspi_xip_ctrl.sv
// tb_qspi_xip_ctrl: directed bench for qspi_xip_ctrl with an inline flash stub (word 0x100 = DEADBEEF)
module tb_qspi_xip_ctrl;
  localparam int CS_GAP = 2;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, req3 = 1'b0;
  logic [23:0] if_addr = '0, d_addr = '0;
  logic if_gnt, d_gnt, if_rv, d_rv, g3, dg3, rv3, drv3;
  logic [31:0] if_rd, d_rd, rd3, drd3;
  logic [3:0] io1, iot1, io3, iot3, stub_io = 4'h0;
  logic ck1, cs1, ck3, cs3;
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  qspi_xip_ctrl #(.SCK_HALF(1), .CS_GAP(CS_GAP), .MODE_BYTE(8'hFF)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ifetch_req_i(if_req), .ifetch_addr_i(if_addr), .ifetch_gnt_o(if_gnt),
    .ifetch_rvalid_o(if_rv), .ifetch_rdata_o(if_rd),
    .data_req_i(d_req), .data_addr_i(d_addr), .data_gnt_o(d_gnt),
    .data_rvalid_o(d_rv), .data_rdata_o(d_rd),
    .qspi_io_i(stub_io), .qspi_io_o(io1), .qspi_io_t(iot1), .qspi_ck_o(ck1), .qspi_cs_o(cs1)
  );

  qspi_xip_ctrl #(.SCK_HALF(3), .CS_GAP(CS_GAP), .MODE_BYTE(8'hFF)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .ifetch_req_i(req3), .ifetch_addr_i(if_addr), .ifetch_gnt_o(g3),
    .ifetch_rvalid_o(rv3), .ifetch_rdata_o(rd3),
    .data_req_i(1'b0), .data_addr_i(24'h0), .data_gnt_o(dg3),
    .data_rvalid_o(drv3), .data_rdata_o(drd3),
    .qspi_io_i(stub_io), .qspi_io_o(io3), .qspi_io_t(iot3), .qspi_ck_o(ck3), .qspi_cs_o(cs3)
  );

  // flash stub: follows whichever controller sel points at
  logic s_ck, s_cs;
  logic [3:0] s_io, s_iot;
  assign s_ck  = sel ? ck3 : ck1;
  assign s_cs  = sel ? cs3 : cs1;
  assign s_io  = sel ? io3 : io1;
  assign s_iot = sel ? iot3 : iot1;
  int rises = 0;
  logic [7:0] cmd_sh = '0, stub_cmd = '0;
  logic [23:0] addr_sh = '0, stub_addr = '0;

  function automatic logic [31:0] mem(input logic [23:0] a);
    return a == 24'h000100 ? 32'hDEADBEEF : {8'h5A, a};
  endfunction

  always @(posedge s_ck or negedge s_cs) begin
    if (!s_ck) rises = 0;
    else if (!s_cs) begin
      rises++;
      if (rises <= 8) cmd_sh = {cmd_sh[6:0], s_io[0]};
      else if (rises <= 14) addr_sh = {addr_sh[19:0], s_io};
      if (rises == 8) stub_cmd = cmd_sh;
      if (rises == 14) stub_addr = addr_sh;
    end
  end

  always @(negedge s_ck) begin : stub_drive
    logic [31:0] w;
    int k;
    if (!s_cs && rises >= 20 && rises <= 27) begin
      w = mem(addr_sh);
      k = rises - 20;
      stub_io = w[8*(k/2) + ((k % 2 == 1) ? 0 : 4) +: 4];
    end
  end

  logic prev_if = 1'b0, prev_d = 1'b0;
  int hi_run = 0, last_hi = 0;
  always @(negedge clk) begin
    if (!cs1 && (if_gnt || d_gnt)) begin failures++; $display("FAIL gnt_while_busy: gnt=%b%b with cs low", if_gnt, d_gnt); end
    if (if_rv && d_rv) begin failures++; $display("FAIL rvalid_onehot: both rvalid high"); end
    if ((if_rv && prev_if) || (d_rv && prev_d)) begin failures++; $display("FAIL rvalid_pulse: rvalid high 2 cycles"); end
    if (!s_cs && (rises > 16 || (rises == 16 && !s_ck)) && s_iot !== 4'hF) begin
      failures++; $display("FAIL io_t_turnaround: io_t=%h want F during dummy/data", s_iot);
    end
    prev_if = if_rv;
    prev_d  = d_rv;
    if (cs1) hi_run++;
    else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return if_gnt;
      1: return d_gnt;
      2: return if_rv;
      3: return d_rv;
      4: return g3;
      5: return rv3;
      default: return if_gnt | d_gnt;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      seen = sig(w);
    end
    if (!seen) begin failures++; $display("FAIL %s timeout: signal %0d not seen in 1000 cycles", nm, w); end
  endtask

  task automatic set_req(input bit p, input logic [23:0] a, input logic v);
    if (sel) begin req3 = v; if_addr = a; end
    else if (p) begin d_req = v; d_addr = a; end
    else begin if_req = v; if_addr = a; end
  endtask

  task automatic do_read(input bit p, input logic [23:0] a, input int lat, input logic [31:0] exp_d, input string nm);
    int t0;
    logic [31:0] rd;
    logic other;
    @(posedge clk); #1 set_req(p, a, 1'b1);
    wait_for(sel ? 4 : p ? 1 : 0, nm);
    t0 = cyc;
    @(posedge clk); #1 set_req(p, a, 1'b0);
    wait_for(sel ? 5 : p ? 3 : 2, nm);
    rd = sel ? rd3 : p ? d_rd : if_rd;
    other = sel ? drv3 : p ? if_rv : d_rv;
    checks++; if (cyc - t0 !== lat) begin failures++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - t0, lat); end
    checks++; if (rd !== exp_d) begin failures++; $display("FAIL %s rdata: got %h want %h", nm, rd, exp_d); end
    checks++; if (stub_addr !== (a & 24'hFFFFFC)) begin failures++; $display("FAIL %s flash_addr: got %h want %h", nm, stub_addr, a & 24'hFFFFFC); end
    checks++; if (stub_cmd !== 8'hEB) begin failures++; $display("FAIL %s cmd: got %h want eb", nm, stub_cmd); end
    checks++; if (other !== 1'b0) begin failures++; $display("FAIL %s other_rvalid: got %b want 0", nm, other); end
  endtask

  task automatic test_reset();
    if_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cs1 !== 1'b1 || cs3 !== 1'b1) begin failures++; $display("FAIL reset_cs: got %b%b want 11", cs1, cs3); end
    checks++; if (ck1 !== 1'b0) begin failures++; $display("FAIL reset_ck: got %b want 0", ck1); end
    checks++; if (iot1 !== 4'hF) begin failures++; $display("FAIL reset_io_t: got %h want f", iot1); end
    checks++; if (io1 !== 4'h0) begin failures++; $display("FAIL reset_io_o: got %h want 0", io1); end
    checks++; if ({if_gnt, d_gnt, if_rv, d_rv} !== 4'b0) begin failures++; $display("FAIL reset_hs: got %b want 0000", {if_gnt, d_gnt, if_rv, d_rv}); end
    checks++; if (if_rd !== 32'h0 || d_rd !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h/%h want 0", if_rd, d_rd); end
    @(posedge clk); #1 if_req = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_ifetch_read();
    do_read(1'b0, 24'h000100, 56, 32'hDEADBEEF, "ifetch_0x100");
  endtask

  task automatic test_data_unaligned();
    do_read(1'b1, 24'h000103, 56, 32'hDEADBEEF, "data_0x103");
  endtask

  task automatic test_arbitration();
    int t_rv;
    @(posedge clk); #1 if_req = 1'b1; if_addr = 24'h100; d_req = 1'b1; d_addr = 24'h8;
    wait_for(6, "arb1_gnt");
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin failures++; $display("FAIL arb1_first: got if/d=%b want 10", {if_gnt, d_gnt}); end
    @(posedge clk); #1 if_req = 1'b0;
    wait_for(2, "arb1_if_rv");
    t_rv = cyc;
    checks++; if (if_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL arb1_if_rdata: got %h want deadbeef", if_rd); end
    wait_for(1, "arb1_d_gnt");
    checks++; if (cyc - t_rv !== CS_GAP) begin failures++; $display("FAIL arb1_gap: got %0d want %0d", cyc - t_rv, CS_GAP); end
    @(posedge clk); #1 d_req = 1'b0;
    wait_for(3, "arb1_d_rv");
    checks++; if (d_rd !== 32'h5A000008) begin failures++; $display("FAIL arb1_d_rdata: got %h want 5a000008", d_rd); end
    do_read(1'b0, 24'h000004, 56, 32'h5A000004, "single_if");
    @(posedge clk); #1 if_req = 1'b1; if_addr = 24'h100; d_req = 1'b1; d_addr = 24'hC;
    wait_for(6, "arb2_gnt");
    checks++; if ({if_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL arb2_first: got if/d=%b want 01", {if_gnt, d_gnt}); end
    @(posedge clk); #1 d_req = 1'b0;
    wait_for(3, "arb2_d_rv");
    checks++; if (d_rd !== 32'h5A00000C) begin failures++; $display("FAIL arb2_d_rdata: got %h want 5a00000c", d_rd); end
    wait_for(0, "arb2_if_gnt");
    @(posedge clk); #1 if_req = 1'b0;
    wait_for(2, "arb2_if_rv");
    checks++; if (if_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL arb2_if_rdata: got %h want deadbeef", if_rd); end
  endtask

  task automatic test_reset_abort();
    int nrv = 0;
    @(posedge clk); #1 if_req = 1'b1; if_addr = 24'h100;
    wait_for(0, "abort_gnt");
    @(posedge clk); #1 if_req = 1'b0;
    repeat (47) @(posedge clk);
    @(negedge clk);
    checks++; if (cs1 !== 1'b0 || iot1 !== 4'hF) begin failures++; $display("FAIL abort_in_data: cs=%b io_t=%h want 0/f", cs1, iot1); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({cs1, ck1, iot1} !== 6'b10_1111) begin failures++; $display("FAIL abort_pads: cs/ck/io_t=%b want 101111", {cs1, ck1, iot1}); end
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (if_rv || d_rv) nrv++;
    end
    checks++; if (nrv !== 0) begin failures++; $display("FAIL abort_no_rvalid: got %0d rvalid pulses want 0", nrv); end
    do_read(1'b0, 24'h000100, 56, 32'hDEADBEEF, "after_abort");
  endtask

  task automatic test_back_to_back();
    do_read(1'b0, 24'h000000, 56, 32'h5A000000, "b2b_0");
    do_read(1'b0, 24'h000004, 56, 32'h5A000004, "b2b_4");
    checks++; if (last_hi < CS_GAP) begin failures++; $display("FAIL b2b_cs_gap: cs high %0d cycles want >= %0d", last_hi, CS_GAP); end
  endtask

  task automatic test_slow();
    sel = 1'b1;
    do_read(1'b0, 24'h000100, 166, 32'hDEADBEEF, "slow_sck_half3");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifetch_read();
    test_data_unaligned();
    test_arbitration();
    test_reset_abort();
    test_back_to_back();
    test_slow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
